// File: rtl/prng_lcg.sv
// Lehmer / Park-Miller generator: rand_num = (a * operand) mod m, computed with
// 32 shift-add multiply steps and 64 restoring-division steps (97-cycle latency).
module prng_lcg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m,
    input  logic [31:0] a,
    input  logic [31:0] seed,
    input  logic        start,
    input  logic        cont,
    output logic        done,
    output logic [31:0] rand_num
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] m_q;
    logic [31:0] a_q;
    logic [31:0] op_q;
    logic [63:0] prod;
    logic [31:0] rem;
    logic [6:0]  cnt;

    logic [32:0] trial;
    logic [31:0] diff;
    logic        fits;

    // Next partial remainder: shift in the next product bit; subtract if m fits.
    always_comb begin
        trial = {rem, prod[63]};
        fits  = (trial >= {1'b0, m_q});
        diff  = trial[31:0] - m_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            rand_num <= 32'd0;
            m_q      <= 32'd0;
            a_q      <= 32'd0;
            op_q     <= 32'd0;
            prod     <= 64'd0;
            rem      <= 32'd0;
            cnt      <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= m;
                        a_q   <= a;
                        op_q  <= cont ? rand_num : seed;
                        prod  <= 64'd0;
                        cnt   <= 7'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // MSB-first shift-add over the operand bits
                    prod <= {prod[62:0], 1'b0} + (op_q[31] ? {32'd0, a_q} : 64'd0);
                    op_q <= {op_q[30:0], 1'b0};
                    if (cnt == 7'd31) begin
                        cnt   <= 7'd0;
                        rem   <= 32'd0;
                        state <= DIV;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                DIV: begin
                    if (cnt == 7'd64) begin
                        // prod has rotated a full turn, so its low word is intact for m=0
                        rand_num <= (m_q == 32'd0) ? prod[31:0] : rem;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        rem  <= fits ? diff : trial[31:0];
                        prod <= {prod[62:0], prod[63]};
                        cnt  <= cnt + 7'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_lcg.sv
// Directed-vector bench for prng_lcg: table of requests with known results,
// plus handshake, latency, input-isolation and asynchronous-reset sequences.
module tb_prng_lcg;

    logic        clk;
    logic        rst;
    logic [31:0] m, a, seed;
    logic        start, cont;
    logic        done;
    logic [31:0] rand_num;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] m;
        logic [31:0] a;
        logic [31:0] seed;
        logic        cont;
        logic [31:0] expect_rand;
    } vec_t;

    vec_t tbl[11];

    prng_lcg dut (
        .clk      (clk),
        .rst      (rst),
        .m        (m),
        .a        (a),
        .seed     (seed),
        .start    (start),
        .cont     (cont),
        .done     (done),
        .rand_num (rand_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Full 4-phase request; inputs are scrambled right after acceptance so any
    // leak of live inputs into the running computation corrupts the result.
    task automatic run_req(input vec_t v);
        int          lat;
        logic        held;
        logic [31:0] r;
        @(negedge clk);
        m = v.m; a = v.a; seed = v.seed; cont = v.cont; start = 1'b1;
        @(posedge clk);
        #1;
        m = $urandom; a = $urandom; seed = $urandom; cont = 1'($urandom_range(0, 1));
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'd97);
        check({v.name, " rand"}, rand_num, v.expect_rand);
        r    = rand_num;
        held = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!done || rand_num !== r) held = 1'b0;
        end
        check({v.name, " held"}, {31'd0, held}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({v.name, " done_fall"}, {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({v.name, " rand_after"}, rand_num, r);
    endtask

    initial begin
        tbl[0]  = '{"cont_after_reset", 32'd2147483647, 32'd16807, 32'd5,        1'b1, 32'd0};
        tbl[1]  = '{"reseed0",   32'd2147483647, 32'd16807, 32'h7B818935, 1'b0, 32'h755735EB};
        tbl[2]  = '{"reseed1",   32'd2147483647, 32'd16807, 32'h142E4ECE, 1'b0, 32'h6C37C0BB};
        tbl[3]  = '{"reseed2",   32'd2147483647, 32'd16807, 32'h68493A1B, 1'b0, 32'h1F85F81A};
        tbl[4]  = '{"reseed3",   32'd2147483647, 32'd16807, 32'h73F12C81, 1'b0, 32'h5EA1049E};
        tbl[5]  = '{"chain0",    32'd2147483647, 32'd16807, 32'd1,        1'b0, 32'd16807};
        tbl[6]  = '{"chain1",    32'd2147483647, 32'd16807, 32'h00012345, 1'b1, 32'd282475249};
        tbl[7]  = '{"chain2",    32'd2147483647, 32'd16807, 32'h00054321, 1'b1, 32'd1622650073};
        tbl[8]  = '{"m_zero",    32'h00000000,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001};
        tbl[9]  = '{"m_one",     32'h00000001,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000};
        tbl[10] = '{"m_max",     32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000};

        rst = 1'b0; start = 1'b0; cont = 1'b0;
        m = 32'd0; a = 32'd0; seed = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset rand", rand_num, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 11; i++) run_req(tbl[i]);

        // Abort mid-computation; rand_num is nonzero from the previous chain
        // setup only if m_max left it so, so seed a known nonzero value first.
        run_req(tbl[5]);
        @(negedge clk);
        m = tbl[1].m; a = tbl[1].a; seed = tbl[1].seed; cont = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst done", {31'd0, done}, 32'd0);
        check("async_rst rand", rand_num, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst rand", rand_num, 32'd0);
        run_req(tbl[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prng_lcg.md
# prng_lcg

Multiplicative linear-congruential (Lehmer / Park–Miller) pseudo-random number generator. On each request it computes rand = (a × seed) mod m using fully general 32-bit operands, with the modulus and multiplier supplied as run-time inputs. It sits as a request/acknowledge slave beside a controller that either reseeds it on every request or chains from its own previous output. The arithmetic is multi-cycle: shift-add multiply followed by restoring division, with no hard multiplier or divider.

## Interface
- No parameters; all widths fixed at 32 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets).
- m  input  32  modulus, unsigned; sampled at request acceptance.
- a  input  32  multiplier, unsigned; sampled at request acceptance.
- seed  input  32  seed value, unsigned; sampled at request acceptance when cont=0.
- start  input  1  request; level-held by the master until done is seen.
- cont  input  1  continue mode; 1 = use the previous rand as seed, ignoring the seed input.
- done  output  1  acknowledge; rand is valid while high.
- rand  output  32  result register.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: when start=1 at a clock edge, latch a, m, and the operand (seed, or rand if cont=1). Clear the 64-bit product. Go to MUL.
- MUL: 32 cycles of shift-add. Form the full 64-bit product a × operand, with no truncation.
- DIV: 64 cycles of restoring division of the product by m. Use a 33-bit partial remainder, keeping the remainder only.
- DIV→DONE transition: write the remainder to rand and set done=1.
- m=0: rand = product[31:0], i.e. mod 2^32. m=1: rand=0.
- The result is exact for any operands; seed ≥ m and a ≥ m are legal.
- DONE: hold done=1 and rand while start=1. When start=0 is sampled, clear done and go to IDLE.
- A new request is accepted only in IDLE. start is ignored in MUL and DIV.
- Inputs m, a, seed and cont may change freely after acceptance without affecting the running computation.
- rand changes only on the DIV→DONE transition and on reset.

## Timing
- Reset (async assert, any state): state=IDLE, done=0, rand=0, and all datapath registers cleared.
- After reset deasserts, the first edge with start=1 is acceptance (edge E0).
- E1–E32 perform MUL and E33–E96 perform DIV.
- At E97, rand is updated and done rises. Latency from acceptance to done is 97 cycles, fixed and data-independent.
- done falls on the first edge at which start=0 is sampled in DONE.
- A new request can be accepted one edge after done falls; minimum cycle is 99 clocks.
- If start is still 1 in IDLE (start held across done falling): not possible, because DONE exits only on start=0.
- Reset mid-MUL or mid-DIV aborts the computation: done=0, rand=0, and no partial result is written.
- cont=1 immediately after reset chains from rand=0, giving result 0.

## Test plan
- With m=2147483647, a=16807, run four reseeded requests with 4-phase handshake, cont=0:
  - seed=0x7B818935 → rand=0x755735EB
  - seed=0x142E4ECE → rand=0x6C37C0BB
  - seed=0x68493A1B → rand=0x1F85F81A
  - seed=0x73F12C81 → rand=0x5EA1049E
- Chaining: same m and a, seed=1, cont=0 → rand=16807. Next request with cont=1 → 282475249. Next with cont=1 → 1622650073.
- Handshake and latency:
  - done rises exactly 97 cycles after the start-sampled edge.
  - done stays high while start is held for 20 extra cycles.
  - done falls on the edge start=0 is sampled.
  - rand is unchanged afterward.
  - Toggling seed or m during MUL has no effect on the result.
- Edge moduli, with a=0xFFFFFFFF and seed=0xFFFFFFFF:
  - m=0 → rand=0x00000001
  - m=1 → rand=0
  - m=0xFFFFFFFF → rand=0
- Reset: assert rst=0 at cycle 50 of a computation → done=0 and rand=0 immediately, with no clock needed. After release, a fresh request completes normally with the correct value.
